// File: rtl/upa1_mc_if.sv
// upa1_mc_if -- request/result/load bundle for the multi-channel a1 update stage.
//   master: adaptive-predictor control side (drives requests, loads, out_ready)
//   slave : upa1_mc
//   in_valid/in_ready/in_ch/PK0/PK1/SIGPK/A2P/TR : update request handshake
//   ld_en/ld_ch/ld_data                          : host coefficient load
//   out_valid/out_ready/out_ch/A1P               : result handshake
interface upa1_mc_if #(
    parameter int CHW = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [CHW-1:0]  in_ch;
    logic            PK0;
    logic            PK1;
    logic            SIGPK;
    logic [15:0]     A2P;
    logic            TR;
    logic            ld_en;
    logic [CHW-1:0]  ld_ch;
    logic [15:0]     ld_data;
    logic            out_valid;
    logic            out_ready;
    logic [CHW-1:0]  out_ch;
    logic [15:0]     A1P;

    modport master (
        output in_valid, in_ch, PK0, PK1, SIGPK, A2P, TR,
        output ld_en, ld_ch, ld_data, out_ready,
        input  in_ready, out_valid, out_ch, A1P
    );

    modport slave (
        input  in_valid, in_ch, PK0, PK1, SIGPK, A2P, TR,
        input  ld_en, ld_ch, ld_data, out_ready,
        output in_ready, out_valid, out_ch, A1P
    );
endinterface

// File: rtl/upa1_mc.sv
// upa1_mc -- multi-channel pipelined a1 update for the ADPCM pole predictor.
// Holds one a1 coefficient per channel, applies gain/leak update, limits the
// result against LIMIT - A2P and zeroes it on a tone transition.
// Two stages: S1 (request regs + combinational update) -> out regs.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : upa1_mc_if.slave (request, load and result handshakes)
module upa1_mc #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int GAIN       = 192,
    parameter int LEAK_SHIFT = 8,
    parameter int LIMIT      = 15360
) (
    input  logic         clk,
    input  logic         reset,
    upa1_mc_if.slave     bus
);
    localparam int STAGES = 2;
    localparam logic signed [15:0] GAIN16  = 16'(GAIN);
    localparam logic signed [15:0] LIMIT16 = 16'(LIMIT);

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic           pk0;
        logic           pk1;
        logic           sigpk;
        logic [15:0]    a2p;
        logic           tr;
    } req_t;

    // vld_pipe[1]: S1 occupied, vld_pipe[2]: result presented on out_*
    logic [STAGES:1]        vld_pipe;
    req_t                   s1_q;
    logic [NCH-1:0][15:0]   coef;
    logic [CHW-1:0]         out_ch_q;
    logic [15:0]            a1p_q;

    logic                   s1_adv;
    logic                   in_ready;
    logic signed [15:0]     a1, uga1, ula1, a1t, bnd, a1p_n;

    assign s1_adv        = vld_pipe[1] & (~vld_pipe[2] | bus.out_ready);
    assign in_ready      = ~vld_pipe[1] | s1_adv;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_pipe[2];
    assign bus.out_ch    = out_ch_q;
    assign bus.A1P       = a1p_q;

    // S1 update arithmetic, all mod 2^16. An out-of-range channel matches no
    // coefficient, so it computes from A1=0 and never writes back.
    always_comb begin
        a1 = '0;
        for (int i = 0; i < NCH; i++)
            if (32'(s1_q.ch) == i) a1 = coef[i];
        uga1  = s1_q.sigpk ? 16'sd0 : ((s1_q.pk0 ^ s1_q.pk1) ? -GAIN16 : GAIN16);
        ula1  = -(a1 >>> LEAK_SHIFT);
        a1t   = a1 + uga1 + ula1;
        bnd   = LIMIT16 - signed'(s1_q.a2p);
        a1p_n = a1t;
        if (a1t > bnd)
            a1p_n = bnd;
        else if (a1t < -bnd)
            a1p_n = -bnd;
        if (s1_q.tr)
            a1p_n = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
        end else begin
            if (in_ready) begin
                vld_pipe[1] <= bus.in_valid;
                if (bus.in_valid)
                    s1_q <= '{ch: bus.in_ch, pk0: bus.PK0, pk1: bus.PK1,
                               sigpk: bus.SIGPK, a2p: bus.A2P, tr: bus.TR};
            end
            if (s1_adv)
                vld_pipe[2] <= 1'b1;
            else if (bus.out_ready)
                vld_pipe[2] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_ch_q <= '0;
            a1p_q    <= '0;
        end else if (s1_adv) begin
            out_ch_q <= s1_q.ch;
            a1p_q    <= a1p_n;
        end
    end

    // Write-back lands on the same edge S1 advances, so a following request
    // for the same channel (entering S1 on that edge) reads the new value.
    // A host load to the same channel on that edge takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coef <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.ld_en && 32'(bus.ld_ch) == i)
                    coef[i] <= bus.ld_data;
                else if (s1_adv && 32'(s1_q.ch) == i)
                    coef[i] <= a1p_n;
            end
        end
    end
endmodule

// File: tb/tb_upa1_mc.sv
// tb_upa1_mc -- scoreboard bench for upa1_mc: directed cases with fixed
// expected values, then randomized traffic against a transaction-level model.
module tb_upa1_mc;
    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int GAIN  = 192;
    localparam int LIMIT = 15360;

    typedef struct {
        int          ch;
        logic [15:0] a1p;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   rdy_mode;      // 0: always ready, 1: stalled, 2: random
    logic rnd_rdy;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   model_coef[NCH];

    upa1_mc_if #(.CHW(CHW)) bus ();

    upa1_mc #(.NCH(NCH), .CHW(CHW), .GAIN(GAIN), .LEAK_SHIFT(8), .LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_rdy = ($urandom_range(0, 3) != 0);
    end
    assign bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : rnd_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // a1 update from the arithmetic rules: gain step, floor(a1/256) leak,
    // 16-bit wrap, clamp to +/-(LIMIT - a2p), zero on tone transition.
    function automatic logic [15:0] ref_a1p(int a1, bit pk0, bit pk1, bit sigpk, int a2p, bit tr);
        int t, b, leak;
        logic signed [15:0] w;
        if (tr) return 16'h0000;
        leak = int'($floor(real'(a1) / 256.0));
        t = a1 - leak;
        if (!sigpk) t = t + ((pk0 != pk1) ? -GAIN : GAIN);
        w = t[15:0];
        t = w;
        b = LIMIT - a2p;
        if (t > b) t = b;
        else if (t < -b) t = -b;
        return t[15:0];
    endfunction

    // Monitor: compare every presented result with the queue head; pop on transfer.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got ch %0d A1P %h with empty scoreboard", bus.out_ch, bus.A1P);
            end else begin
                chk("out_ch", 32'(bus.out_ch), 32'(q[0].ch));
                chk("A1P", 32'(bus.A1P), 32'(q[0].a1p));
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    // exp < 0: expected value comes from the model; otherwise a fixed constant.
    task automatic send_req(input int ch, input bit pk0, input bit pk1, input bit sigpk,
                            input int a2p, input bit tr, input int exp);
        bit ok = 0;
        logic [15:0] r;
        logic signed [15:0] s;
        bus.in_valid = 1'b1;
        bus.in_ch    = ch[CHW-1:0];
        bus.PK0      = pk0;
        bus.PK1      = pk1;
        bus.SIGPK    = sigpk;
        bus.A2P      = a2p[15:0];
        bus.TR       = tr;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        if (!ok) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            r = (exp < 0) ? ref_a1p(model_coef[ch], pk0, pk1, sigpk, a2p, tr) : exp[15:0];
            s = r;
            model_coef[ch] = s;
            q.push_back('{ch: ch, a1p: r});
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid) ok = 1;
        end
        if (!ok) chk("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int ch, input logic [15:0] data);
        logic signed [15:0] s;
        bus.ld_en   = 1'b1;
        bus.ld_ch   = ch[CHW-1:0];
        bus.ld_data = data;
        @(posedge clk);
        #1 bus.ld_en = 1'b0;
        s = data;
        model_coef[ch] = s;
    endtask

    initial begin
        reset = 1'b1;
        rdy_mode = 0;
        bus.in_valid = 0; bus.in_ch = '0; bus.PK0 = 0; bus.PK1 = 0; bus.SIGPK = 0;
        bus.A2P = '0; bus.TR = 0; bus.ld_en = 0; bus.ld_ch = '0; bus.ld_data = '0;
        foreach (model_coef[i]) model_coef[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("rst_A1P", 32'(bus.A1P), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // gain accumulates back-to-back on ch0
        send_req(0, 0, 0, 0, 0, 0, 16'h00C0);
        send_req(0, 0, 0, 0, 0, 0, 16'h0180);
        // loaded coefficient with opposite signs
        wait_idle();
        do_load(1, 16'h3000);
        send_req(1, 1, 0, 0, 0, 0, 16'h2F10);
        // positive and negative clamp
        wait_idle();
        do_load(2, 16'h3C00);
        send_req(2, 0, 0, 0, 16'h0C00, 0, 16'h3000);
        wait_idle();
        do_load(2, 16'hC400);
        send_req(2, 1, 0, 0, 0, 0, 16'hC400);
        // tone transition, then leak-only, then confirm ch1 was zeroed
        send_req(1, 0, 0, 0, 0, 1, 16'h0000);
        send_req(0, 0, 0, 1, 0, 0, 16'h017F);
        send_req(1, 0, 0, 1, 0, 0, 16'h0000);
        // host load on the same edge as the ch2 write-back must win
        wait_idle();
        send_req(2, 0, 0, 1, 0, 0, 16'hC43C);
        do_load(2, 16'h1234);
        send_req(2, 0, 0, 1, 0, 0, 16'h1222);

        // backpressure: third request blocks, head result holds
        wait_idle();
        rdy_mode = 1;
        send_req(3, 0, 0, 0, 0, 0, 16'h00C0);
        send_req(3, 0, 0, 0, 0, 0, 16'h0180);
        fork
            send_req(3, 0, 0, 0, 0, 0, 16'h023F);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("stall_A1P", 32'(bus.A1P), 32'h00C0);
                end
                @(posedge clk);
                #1 rdy_mode = 0;
            end
        join

        // reset mid-flight
        wait_idle();
        send_req(0, 0, 0, 0, 0, 0, 16'h023E);
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_A1P", 32'(bus.A1P), 32'd0);
        q.delete();
        foreach (model_coef[i]) model_coef[i] = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        send_req(0, 0, 0, 0, 0, 0, 16'h00C0);

        // randomized traffic with random backpressure and idle-time loads
        rdy_mode = 2;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                wait_idle();
                do_load(int'($urandom_range(0, NCH - 1)), 16'($urandom()));
            end
            send_req(int'($urandom_range(0, NCH - 1)), 1'($urandom()), 1'($urandom()),
                     ($urandom_range(0, 5) == 0), int'($urandom_range(0, 24576)) - 12288,
                     ($urandom_range(0, 15) == 0), -1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        wait_idle();
        chk("final_drain", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
